sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/fifo_pkg.sv | 15 +
 rtl/sync_fifo_if.sv | 39 +++
 rtl/fifo_ram.sv | 26 ++
 rtl/sync_fifo.sv | 109 ++++++++++
 tb/tb_sync_fifo.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO types and helpers.
// Default geometry plus a constant-foldable clog2.
package fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer bundle of the synchronous FIFO.
// Master drives requests; slave (the FIFO) drives status.
interface sync_fifo_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
);

  localparam int CW = clog2(DEPTH) + 1;

  logic             w_en;
  logic [WIDTH-1:0] w_data;
  logic             r_en;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output w_en, w_data, r_en,
    input  r_data, r_valid, full, empty,
    input  almost_full, almost_empty,
    input  count, overflow, underflow
  );

  modport slave (
    input  w_en, w_data, r_en,
    output r_data, r_valid, full, empty,
    output almost_full, almost_empty,
    output count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ram.sv
// FIFO storage: one synchronous write port,
// one asynchronous read port, contents never reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO: pointers, registered flags, sticky
// errors, and registered or fall-through read mode.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input logic        clk,
  input logic        rst,
  sync_fifo_if.slave bus
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    rp_q, rp_d;
  logic [PW-1:0]    cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             af_q, af_d;
  logic             ae_q, ae_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             rv_q, rv_d;
  logic [WIDTH-1:0] rd_q, rd_d;
  logic [WIDTH-1:0] ram_rdata;
  logic             wr_acc;
  logic             rd_acc;

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wp_q[AW-1:0]),
    .wdata_i (bus.w_data),
    .raddr_i (rp_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  // Flags come from next-state pointers so they
  // are registered yet current the cycle after.
  always_comb begin
    wr_acc  = bus.w_en & ~full_q;
    rd_acc  = bus.r_en & ~empty_q;
    wp_d    = wp_q + PW'(wr_acc);
    rp_d    = rp_q + PW'(rd_acc);
    cnt_d   = wp_d - rp_d;
    full_d  = (wp_d[AW] != rp_d[AW]) &&
              (wp_d[AW-1:0] == rp_d[AW-1:0]);
    empty_d = (wp_d == rp_d);
    af_d    = int'(cnt_d) >= AFULL_TH;
    ae_d    = int'(cnt_d) <= AEMPTY_TH;
    ovf_d   = ovf_q | (bus.w_en & full_q);
    udf_d   = udf_q | (bus.r_en & empty_q);
    rv_d    = rd_acc;
    rd_d    = rd_acc ? ram_rdata : rd_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
    end
  end

  // Fall-through masks the unreset RAM while empty.
  assign bus.r_data = (FWFT != 0)
                    ? (empty_q ? '0 : ram_rdata)
                    : rd_q;
  assign bus.r_valid = (FWFT != 0) ? ~empty_q : rv_q;

  assign bus.count        = cnt_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: registered and fall-through
// instances share stimulus and a queue-based model.
module tb_sync_fifo;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sync_fifo_if #(.WIDTH(8), .DEPTH(4)) bus0 ();
  sync_fifo_if #(.WIDTH(8), .DEPTH(4)) bus1 ();

  sync_fifo #(
    .WIDTH(8), .DEPTH(4), .AFULL_TH(3),
    .AEMPTY_TH(1), .FWFT(0)
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  sync_fifo #(
    .WIDTH(8), .DEPTH(4), .AFULL_TH(3),
    .AEMPTY_TH(1), .FWFT(1)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int checks   = 0;
  int failures = 0;

  logic [7:0] q[$];
  bit         m_ovf;
  bit         m_udf;
  bit         m_rv;
  logic [7:0] m_rd;

  task automatic chk(string tag,
                     logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h",
             tag, got, exp);
    end
  endtask

  task automatic check_all();
    int n;
    logic [7:0] head;
    n    = q.size();
    head = (n != 0) ? q[0] : 8'h00;
    chk("cnt0",  32'(bus0.count), 32'(n));
    chk("full0", 32'(bus0.full), 32'(n == 4));
    chk("emp0",  32'(bus0.empty), 32'(n == 0));
    chk("af0",   32'(bus0.almost_full), 32'(n >= 3));
    chk("ae0",   32'(bus0.almost_empty), 32'(n <= 1));
    chk("ovf0",  32'(bus0.overflow), 32'(m_ovf));
    chk("udf0",  32'(bus0.underflow), 32'(m_udf));
    chk("rv0",   32'(bus0.r_valid), 32'(m_rv));
    chk("rd0",   32'(bus0.r_data), 32'(m_rd));
    chk("cnt1",  32'(bus1.count), 32'(n));
    chk("full1", 32'(bus1.full), 32'(n == 4));
    chk("emp1",  32'(bus1.empty), 32'(n == 0));
    chk("af1",   32'(bus1.almost_full), 32'(n >= 3));
    chk("ae1",   32'(bus1.almost_empty), 32'(n <= 1));
    chk("ovf1",  32'(bus1.overflow), 32'(m_ovf));
    chk("udf1",  32'(bus1.underflow), 32'(m_udf));
    chk("rv1",   32'(bus1.r_valid), 32'(n != 0));
    chk("rd1",   32'(bus1.r_data), 32'(head));
  endtask

  task automatic step(bit we, logic [7:0] wd,
                      bit re, bit rs);
    bit is_full;
    bit is_empty;
    rst         = rs;
    bus0.w_en   = we;
    bus1.w_en   = we;
    bus0.w_data = wd;
    bus1.w_data = wd;
    bus0.r_en   = re;
    bus1.r_en   = re;
    @(posedge clk);
    if (rs) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_rv  = 1'b0;
      m_rd  = 8'h00;
    end else begin
      is_full  = (q.size() == 4);
      is_empty = (q.size() == 0);
      if (we && is_full) m_ovf = 1'b1;
      if (re && is_empty) m_udf = 1'b1;
      m_rv = re && !is_empty;
      if (m_rv) m_rd = q.pop_front();
      if (we && !is_full) q.push_back(wd);
    end
    @(negedge clk);
    check_all();
  endtask

  logic [7:0] seq [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] d;

  initial begin
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);

    // fill, then drain with one r_valid pulse each
    for (int i = 0; i < 4; i++) step(1, seq[i], 0, 0);
    chk("full_after4", 32'(bus0.full), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(0, 8'h00, 1, 0);
      chk("drain_data", 32'(bus0.r_data), 32'(seq[i]));
    end
    step(0, 8'h00, 0, 0);

    // write into a full FIFO alongside a pop
    for (int i = 0; i < 4; i++) step(1, seq[i], 0, 0);
    step(1, 8'h55, 1, 0);
    chk("ovf_set", 32'(bus0.overflow), 32'd1);
    chk("ovf_pop", 32'(bus0.r_data), 32'h11);
    chk("ovf_cnt", 32'(bus0.count), 32'd3);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0);

    // read from an empty FIFO alongside a write
    step(1, 8'hA5, 1, 0);
    chk("udf_set", 32'(bus0.underflow), 32'd1);
    chk("udf_cnt", 32'(bus0.count), 32'd1);
    step(0, 8'h00, 1, 0);
    chk("udf_pop", 32'(bus0.r_data), 32'hA5);

    // steady simultaneous traffic at count 2
    step(1, 8'($urandom), 0, 0);
    step(1, 8'($urandom), 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 8'($urandom), 1, 0);
      chk("rw_cnt", 32'(bus0.count), 32'd2);
    end
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);

    // fall-through visibility without r_en
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 1, 0);
    step(1, 8'h7E, 0, 0);
    chk("fwft_rv", 32'(bus1.r_valid), 32'd1);
    chk("fwft_rd", 32'(bus1.r_data), 32'h7E);

    // reset wins over a mid-stream read and write
    step(1, 8'h01, 0, 0);
    step(1, 8'h02, 0, 0);
    step(1, 8'h03, 1, 1);
    chk("rst_cnt", 32'(bus0.count), 32'd0);
    chk("rst_emp", 32'(bus0.empty), 32'd1);
    chk("rst_rd",  32'(bus0.r_data), 32'h00);
    chk("rst_udf", 32'(bus0.underflow), 32'd0);

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      d = 8'($urandom);
      step(bit'($urandom_range(0, 1)), d,
           bit'($urandom_range(0, 1)),
           ($urandom_range(0, 63) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
